// File: rtl/sobel_pkg.sv
// Shared types and arithmetic helpers for the Sobel edge-detection datapath.
// Used by the line buffers and the window kernel.
package sobel_pkg;

  localparam int PIXEL_W   = 8;
  localparam int GRAD_W    = 11;
  localparam int SAT_LIMIT = 255;

  typedef logic        [PIXEL_W-1:0] pixel_t;
  typedef logic signed [GRAD_W-1:0]  grad_t;
  typedef logic        [GRAD_W-1:0]  mag_t;

  // a + 2b + c; at most 1020, so it is always positive as an 11-bit signed value
  function automatic grad_t weighted_sum(input pixel_t a, input pixel_t b, input pixel_t c);
    mag_t s;
    s = mag_t'(a) + (mag_t'(b) << 1) + mag_t'(c);
    return grad_t'(s);
  endfunction

  function automatic mag_t abs_grad(input grad_t g);
    return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
  endfunction

  function automatic pixel_t saturate(input mag_t m);
    return (m > mag_t'(SAT_LIMIT)) ? pixel_t'(SAT_LIMIT) : m[PIXEL_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_position_counter.sv
// Column/row position tracker for the 3x3 window; flags pixels whose window
// lies fully inside the current frame.
module sobel_position_counter #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  output logic o_qualify
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_last;
  logic          w_row_last;

  assign w_col_last = (r_col == CW'(WIDTH - 1));
  assign w_row_last = (r_row == RW'(HEIGHT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_enable) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Uses the position of the pixel being captured, i.e. before the increment.
  assign o_qualify = i_enable && (r_row >= RW'(2)) && (r_col >= CW'(2));

endmodule

// File: rtl/sobel_window_kernel.sv
// 3x3 Sobel window and gradient-magnitude pipeline: capture, gradient, magnitude.
// Stages after capture are free-running so Enable gaps never stall results.
module sobel_window_kernel
  import sobel_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64,
  parameter int THRESHOLD = 128
) (
  input  logic   CLK,
  input  logic   Reset,
  input  logic   Enable,
  input  pixel_t Row0In,
  input  pixel_t Row1In,
  input  pixel_t Row2In,
  output pixel_t DataOut,
  output logic   EdgeOut,
  output logic   ValidOut
);

  localparam mag_t THRESH = mag_t'(THRESHOLD);

  pixel_t r_win [3][3];
  logic   w_qualify;
  logic   r_v0;
  logic   r_v1;
  grad_t  w_gx;
  grad_t  w_gy;
  grad_t  r_gx;
  grad_t  r_gy;
  mag_t   w_mag;
  pixel_t w_sat;
  pixel_t r_data;
  logic   r_edge;
  logic   r_valid;

  sobel_position_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_position (
    .i_clk     (CLK),
    .i_rst     (Reset),
    .i_enable  (Enable),
    .o_qualify (w_qualify)
  );

  // Stage 0: row 0 is the oldest line (top), column 2 the newest pixel.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
      r_v0 <= 1'b0;
    end else begin
      r_v0 <= w_qualify;
      if (Enable) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= Row2In;
        r_win[1][2] <= Row1In;
        r_win[2][2] <= Row0In;
      end
    end
  end

  assign w_gx = weighted_sum(r_win[0][2], r_win[1][2], r_win[2][2])
              - weighted_sum(r_win[0][0], r_win[1][0], r_win[2][0]);
  assign w_gy = weighted_sum(r_win[2][0], r_win[2][1], r_win[2][2])
              - weighted_sum(r_win[0][0], r_win[0][1], r_win[0][2]);

  // Stage 1
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_gx <= '0;
      r_gy <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_gx <= w_gx;
      r_gy <= w_gy;
      r_v1 <= r_v0;
    end
  end

  assign w_mag = abs_grad(r_gx) + abs_grad(r_gy);
  assign w_sat = saturate(w_mag);

  // Stage 2: outputs only move on a qualified result and hold otherwise.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_data  <= '0;
      r_edge  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_v1;
      if (r_v1) begin
        r_data <= w_sat;
        r_edge <= (mag_t'(w_sat) >= THRESH);
      end
    end
  end

  assign DataOut  = r_data;
  assign EdgeOut  = r_edge;
  assign ValidOut = r_valid;

endmodule

// File: tb/tb_sobel_window_kernel.sv
// Directed bench for sobel_window_kernel: flat, vertical/horizontal step frames,
// Enable gaps, asynchronous mid-frame reset and back-to-back frames.
module tb_sobel_window_kernel;

  localparam int W = 64;
  localparam int H = 64;
  localparam int FRAME_VALIDS = (H - 2) * (W - 2);

  logic       CLK = 1'b0;
  logic       Reset;
  logic       Enable;
  logic [7:0] Row0In;
  logic [7:0] Row1In;
  logic [7:0] Row2In;
  logic [7:0] DataOut;
  logic       EdgeOut;
  logic       ValidOut;

  sobel_window_kernel #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .THRESHOLD (128)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Enable   (Enable),
    .Row0In   (Row0In),
    .Row1In   (Row1In),
    .Row2In   (Row2In),
    .DataOut  (DataOut),
    .EdgeOut  (EdgeOut),
    .ValidOut (ValidOut)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  // entry: {capture cycle[31:0], edge, data[7:0]}
  logic [40:0] exp_q[$];

  int          mode = 0;  // 0 flat 100, 1 vertical step, 2 horizontal step
  int          en_cnt = 0;
  int unsigned cap131 = 0;
  int          vcount = 0;
  bit          first_pending = 1'b0;
  int unsigned first_valid_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    if (r < 0) return 8'd0;
    case (mode)
      0:       return 8'd100;
      1:       return (c >= 32) ? 8'd255 : 8'd0;
      default: return (r >= 32) ? 8'd10 : 8'd0;
    endcase
  endfunction

  // Hand-derived results for a window whose newest pixel is (r,c); centre is (r-1,c-1).
  function automatic logic [8:0] expect_at(input int r, input int c);
    case (mode)
      1:       return ((c - 1) == 31 || (c - 1) == 32) ? {1'b1, 8'd255} : 9'd0;
      2:       return ((r - 1) == 31 || (r - 1) == 32) ? {1'b0, 8'd40}  : 9'd0;
      default: return 9'd0;
    endcase
  endfunction

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      Enable = 1'b0;
      Row0In = 8'($urandom);
      Row1In = 8'($urandom);
      Row2In = 8'($urandom);
    end
  endtask

  task automatic drive_pixel(input int r, input int c, input int gap);
    idle(gap);
    @(negedge CLK);
    Enable = 1'b1;
    Row0In = pix(r, c);
    Row1In = pix(r - 1, c);
    Row2In = pix(r - 2, c);
    en_cnt++;
    if (en_cnt == 131) cap131 = cyc + 1;
    if (r >= 2 && c >= 2) exp_q.push_back({cyc + 1, expect_at(r, c)});
  endtask

  task automatic drive_range(input int first, input int last, input int max_gap);
    for (int i = first; i <= last; i++) begin
      drive_pixel(i / W, i % W, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  // scoreboard
  always @(negedge CLK) begin
    logic [40:0] e;
    if (!Reset && ValidOut) begin
      vcount++;
      if (first_pending) begin
        first_valid_cyc = cyc;
        first_pending   = 1'b0;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pixel_edge_data", {55'd0, EdgeOut, DataOut}, {55'd0, e[8:0]});
        check("valid_latency", 64'(cyc - e[40:9]), 64'd2);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset  = 1'b1;
    Enable = 1'b0;
    Row0In = '0;
    Row1In = '0;
    Row2In = '0;
    #12;
    check("reset_data",  {56'd0, DataOut},  64'd0);
    check("reset_edge",  {63'd0, EdgeOut},  64'd0);
    check("reset_valid", {63'd0, ValidOut}, 64'd0);
    @(negedge CLK);
    Reset = 1'b0;

    // flat frame
    mode = 0; vcount = 0;
    drive_range(0, W * H - 1, 0);
    idle(4);
    check("flat_strobes", 64'(vcount), 64'(FRAME_VALIDS));
    check("flat_drained", 64'(exp_q.size()), 64'd0);

    // vertical step, with a pause after the first strong edge to observe hold
    mode = 1; vcount = 0;
    drive_range(0, 2 * W + 33, 0);
    idle(5);
    check("hold_data",  {56'd0, DataOut},  64'd255);
    check("hold_edge",  {63'd0, EdgeOut},  64'd1);
    check("hold_valid", {63'd0, ValidOut}, 64'd0);
    drive_range(2 * W + 34, W * H - 1, 0);
    idle(4);
    check("vstep_strobes", 64'(vcount), 64'(FRAME_VALIDS));
    check("vstep_drained", 64'(exp_q.size()), 64'd0);

    // horizontal step
    mode = 2; vcount = 0;
    drive_range(0, W * H - 1, 0);
    idle(4);
    check("hstep_strobes", 64'(vcount), 64'(FRAME_VALIDS));
    check("hstep_drained", 64'(exp_q.size()), 64'd0);

    // vertical step with random Enable gaps
    mode = 1; vcount = 0;
    drive_range(0, W * H - 1, 5);
    idle(4);
    check("gap_strobes", 64'(vcount), 64'(FRAME_VALIDS));
    check("gap_drained", 64'(exp_q.size()), 64'd0);

    // asynchronous reset in row 10, right after a 255 result appears
    mode = 1; vcount = 0;
    drive_range(0, 10 * W + 35, 0);
    @(negedge CLK);
    Enable = 1'b0;
    #2;
    Reset = 1'b1;
    exp_q.delete();
    #1;
    check("midreset_data",  {56'd0, DataOut},  64'd0);
    check("midreset_edge",  {63'd0, EdgeOut},  64'd0);
    check("midreset_valid", {63'd0, ValidOut}, 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    en_cnt = 0;
    vcount = 0;
    first_pending = 1'b1;
    drive_range(0, W * H - 1, 0);
    idle(4);
    check("postreset_first_latency", 64'(first_valid_cyc - cap131), 64'd2);
    check("postreset_strobes", 64'(vcount), 64'(FRAME_VALIDS));
    check("postreset_drained", 64'(exp_q.size()), 64'd0);

    // two back-to-back frames
    mode = 1; vcount = 0;
    drive_range(0, W * H - 1, 0);
    drive_range(0, 2 * W + 1, 0);
    check("b2b_frame1_only", 64'(vcount), 64'(FRAME_VALIDS));
    drive_range(2 * W + 2, W * H - 1, 0);
    idle(4);
    check("b2b_total", 64'(vcount), 64'(2 * FRAME_VALIDS));
    check("b2b_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
